// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the 5-stage core: drives per-stage hold gates
// and bubble flushes, and times multicycle EX ops with a small down-counter FSM.
module pipeline_ctrl #(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_is_load_i,
  input  logic       ex_multicycle_i,
  input  logic       ex_branch_taken_i,
  input  logic       mem_req_i,
  input  logic       dmem_ready_i,
  input  logic       imem_ready_i,
  output logic       gate_if_o,
  output logic       gate_id_o,
  output logic       gate_ex_o,
  output logic       gate_mem_o,
  output logic       gate_wb_o,
  output logic       flush_id_o,
  output logic       flush_ex_o,
  output logic       flush_mem_o,
  output logic       flush_wb_o,
  output logic       mc_done_o,
  output logic       state_o
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  localparam bit               MC_EN    = (MC_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic dstall, mc_start, mc_hold, mcstall, redirect, luse, rs1_hit, rs2_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    dstall   = mem_req_i & ~dmem_ready_i;
    mc_start = MC_EN & (state_reg == RUN) & ex_valid_i & ex_multicycle_i;
    mc_hold  = (state_reg == MC_BUSY) & (cnt_reg != CNT_ONE);
    mcstall  = mc_start | mc_hold;
    redirect = ex_branch_taken_i & ex_valid_i;
    rs1_hit  = id_rs1_used_i & (id_rs1_i == ex_rd_i);
    rs2_hit  = id_rs2_used_i & (id_rs2_i == ex_rd_i);
    luse     = ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) & (rs1_hit | rs2_hit);

    state_next  = state_reg;
    cnt_next    = cnt_reg;
    gate_if_o   = 1'b0;
    gate_id_o   = 1'b0;
    gate_ex_o   = 1'b0;
    gate_mem_o  = 1'b0;
    gate_wb_o   = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    flush_mem_o = 1'b0;
    flush_wb_o  = 1'b0;
    mc_done_o   = 1'b0;

    // A data-memory wait freezes the whole pipe, including the FSM.
    if (!dstall) begin
      case (state_reg)
        RUN: begin
          if (mc_start) begin
            state_next = MC_BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
        default: begin
          if (cnt_reg != CNT_ONE) begin
            cnt_next = cnt_reg - CNT_ONE;
          end else begin
            state_next = RUN;
            cnt_next   = '0;
          end
        end
      endcase
    end

    if (rst_ni) begin
      mc_done_o = (state_reg == MC_BUSY) & (cnt_reg == CNT_ONE) & ~dstall;
      if (dstall) begin
        gate_if_o  = 1'b1;
        gate_id_o  = 1'b1;
        gate_ex_o  = 1'b1;
        gate_mem_o = 1'b1;
        flush_wb_o = 1'b1;
      end else if (mcstall) begin
        gate_if_o   = 1'b1;
        gate_id_o   = 1'b1;
        gate_ex_o   = 1'b1;
        flush_mem_o = 1'b1;
      end else if (redirect) begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end else if (luse) begin
        gate_if_o  = 1'b1;
        gate_id_o  = 1'b1;
        flush_ex_o = 1'b1;
      end else if (!imem_ready_i) begin
        gate_if_o  = 1'b1;
        flush_id_o = 1'b1;
      end
    end
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed checks of pipeline_ctrl priorities, multicycle timing, async reset,
// plus a random sweep for gate/flush exclusivity.
module tb_pipeline_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       id_rs1_used_i, id_rs2_used_i, ex_valid_i, ex_is_load_i;
  logic       ex_multicycle_i, ex_branch_taken_i, mem_req_i, dmem_ready_i, imem_ready_i;
  logic       gate_if_o, gate_id_o, gate_ex_o, gate_mem_o, gate_wb_o;
  logic       flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o, mc_done_o, state_o;

  int total = 0;
  int bad   = 0;

  // Packed view: {gif,gid,gex,gmem,gwb,fid,fex,fmem,fwb,done,state}
  localparam logic [10:0] G_IF  = 11'b100_0000_0000;
  localparam logic [10:0] G_ID  = 11'b010_0000_0000;
  localparam logic [10:0] G_EX  = 11'b001_0000_0000;
  localparam logic [10:0] G_MEM = 11'b000_1000_0000;
  localparam logic [10:0] G_WB  = 11'b000_0100_0000;
  localparam logic [10:0] F_ID  = 11'b000_0010_0000;
  localparam logic [10:0] F_EX  = 11'b000_0001_0000;
  localparam logic [10:0] F_MEM = 11'b000_0000_1000;
  localparam logic [10:0] F_WB  = 11'b000_0000_0100;
  localparam logic [10:0] DONE  = 11'b000_0000_0010;
  localparam logic [10:0] ST    = 11'b000_0000_0001;
  localparam logic [10:0] MCS   = G_IF | G_ID | G_EX | F_MEM;
  localparam logic [10:0] DSS   = G_IF | G_ID | G_EX | G_MEM | F_WB;

  logic [10:0] outv;
  assign outv = {gate_if_o, gate_id_o, gate_ex_o, gate_mem_o, gate_wb_o,
                 flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o, mc_done_o, state_o};

  pipeline_ctrl #(.MC_LATENCY(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
    .ex_multicycle_i(ex_multicycle_i), .ex_branch_taken_i(ex_branch_taken_i),
    .mem_req_i(mem_req_i), .dmem_ready_i(dmem_ready_i), .imem_ready_i(imem_ready_i),
    .gate_if_o(gate_if_o), .gate_id_o(gate_id_o), .gate_ex_o(gate_ex_o),
    .gate_mem_o(gate_mem_o), .gate_wb_o(gate_wb_o),
    .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o), .flush_mem_o(flush_mem_o),
    .flush_wb_o(flush_wb_o), .mc_done_o(mc_done_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    ex_valid_i = 1'b0; ex_is_load_i = 1'b0; ex_multicycle_i = 1'b0;
    ex_branch_taken_i = 1'b0; mem_req_i = 1'b0;
    dmem_ready_i = 1'b1; imem_ready_i = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [10:0] exp);
    #2;
    total++;
    assert (outv === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, outv, exp);
    end
    $display("check %-22s observed=%b expected=%b", tag, outv, exp);
  endtask

  task automatic start_mul();
    idle();
    ex_valid_i = 1'b1;
    ex_multicycle_i = 1'b1;
  endtask

  logic overlap;

  initial begin
    idle();
    rst_ni = 1'b0;
    mem_req_i = 1'b1; dmem_ready_i = 1'b0; imem_ready_i = 1'b0;
    tick(); tick();
    chk("reset_outputs", 11'b0);
    idle();
    rst_ni = 1'b1;
    tick();
    chk("idle", 11'b0);

    // Load-use on rs2
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd5;
    id_rs1_i = 5'd3; id_rs1_used_i = 1'b1; id_rs2_i = 5'd5; id_rs2_used_i = 1'b1;
    chk("luse_rs2", G_IF | G_ID | F_EX);
    tick();
    idle();
    chk("luse_after", 11'b0);
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd0;
    id_rs2_i = 5'd0; id_rs2_used_i = 1'b1;
    chk("luse_x0", 11'b0);
    ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_used_i = 1'b0;
    chk("luse_unused", 11'b0);
    id_rs2_used_i = 1'b1; imem_ready_i = 1'b0;
    chk("luse_over_imem", G_IF | G_ID | F_EX);
    idle(); imem_ready_i = 1'b0;
    chk("imem_wait", G_IF | F_ID);
    tick();

    // Multicycle op, latency 4
    start_mul();
    chk("mc_c1", MCS);
    tick(); chk("mc_c2", MCS | ST);
    tick(); chk("mc_c3", MCS | ST);
    tick(); chk("mc_c4_done", DONE | ST);
    tick(); idle();
    chk("mc_after", 11'b0);

    // dstall freezes the counter at 2
    start_mul();
    tick(); tick();
    mem_req_i = 1'b1; dmem_ready_i = 1'b0;
    chk("dstall_1", DSS | ST);
    tick(); chk("dstall_2", DSS | ST);
    tick(); dmem_ready_i = 1'b1;
    chk("mc_resume_cnt2", MCS | ST);
    tick(); chk("mc_done_post_dstall", DONE | ST);
    tick(); idle();
    chk("mc_after_dstall", 11'b0);

    // Back-to-back multicycle ops
    start_mul();
    tick(); tick(); tick();
    chk("b2b_done1", DONE | ST);
    tick(); chk("b2b_restart", MCS);
    tick(); chk("b2b_busy", MCS | ST);
    tick(); tick(); chk("b2b_done2", DONE | ST);
    tick(); idle(); tick();

    // Redirect beats load-use and imem wait
    ex_valid_i = 1'b1; ex_branch_taken_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd7;
    id_rs1_i = 5'd7; id_rs1_used_i = 1'b1; imem_ready_i = 1'b0;
    chk("redirect", F_ID | F_EX);
    tick(); idle();
    chk("redirect_after", 11'b0);

    // Async reset mid MC_BUSY at cnt 2
    start_mul();
    tick(); tick();
    chk("pre_reset_busy", MCS | ST);
    rst_ni = 1'b0;
    #1;
    chk("async_reset", 11'b0);
    rst_ni = 1'b1;
    chk("fresh_c1", MCS);
    tick(); chk("fresh_c2", MCS | ST);
    tick(); chk("fresh_c3", MCS | ST);
    tick(); chk("fresh_c4_done", DONE | ST);
    tick(); idle();
    chk("fresh_after", 11'b0);

    // Random sweep: a stage is never both held and flushed
    for (int i = 0; i < 300; i++) begin
      tick();
      id_rs1_i = 5'($urandom_range(0, 3)); id_rs2_i = 5'($urandom_range(0, 3));
      ex_rd_i = 5'($urandom_range(0, 3));
      id_rs1_used_i = 1'($urandom); id_rs2_used_i = 1'($urandom);
      ex_valid_i = 1'($urandom); ex_is_load_i = 1'($urandom);
      ex_multicycle_i = ($urandom_range(0, 3) == 0);
      ex_branch_taken_i = 1'($urandom); mem_req_i = 1'($urandom);
      dmem_ready_i = 1'($urandom); imem_ready_i = 1'($urandom);
      #2;
      overlap = (gate_id_o & flush_id_o) | (gate_ex_o & flush_ex_o) |
                (gate_mem_o & flush_mem_o) | (gate_wb_o & flush_wb_o);
      total++;
      assert (overlap === 1'b0) else begin
        bad++;
        $error("FAIL rand_overlap cycle=%0d observed=%b expected=0 outs=%b", i, overlap, outv);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
